// File: rtl/projectile_slot_allocator.sv
// rtl/projectile_slot_allocator.sv - shared projectile slot pool allocator with player fire cooldown
//
// Allocates projectile object slots for the player and for several enemy
// shooters. Slots 0..ENEMY_PROJECTILES-1 form the enemy pool; the remaining
// high slots form the player pool. One request is served per two cycles:
// IDLE picks who to serve, SERVE_* launches into the lowest free slot of the
// matching pool (or drops the request when that pool is full).
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   startOfFrame        one-cycle pulse per frame, decrements the player cooldown
//   playerFireReq       one-cycle player fire request
//   enemyFireReq        one-cycle fire requests, one bit per enemy shooter
//   slotRelease         one-cycle release pulses from the projectile objects
//   slotActive          registered occupancy per slot
//   slotLaunch          one-cycle launch pulse, at most one bit set
//   launchShooter       shooter index of the current enemy launch, 0 otherwise
//   playerFireDenied    one-cycle pulse when a player request is dropped
//   cooldownBusy        high while the player cooldown count is nonzero
//   dropCount           (PROJ_ALLOC_STATS_EN only) saturating count of
//                       requests dropped because the pool was full
//
// Optional feature macro: PROJ_ALLOC_STATS_EN

module projectile_slot_allocator #(
    parameter int ENEMY_PROJECTILES  = 8,
    parameter int PLAYER_PROJECTILES = 4,
    parameter int ENEMY_SHOOTERS     = 4,
    parameter int COOLDOWN_FRAMES    = 6,
    localparam int TOTAL = ENEMY_PROJECTILES + PLAYER_PROJECTILES,
    localparam int SW    = (ENEMY_SHOOTERS > 1) ? $clog2(ENEMY_SHOOTERS) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      startOfFrame,
    input  logic                      playerFireReq,
    input  logic [ENEMY_SHOOTERS-1:0] enemyFireReq,
    input  logic [TOTAL-1:0]          slotRelease,
    output logic [TOTAL-1:0]          slotActive,
    output logic [TOTAL-1:0]          slotLaunch,
    output logic [SW-1:0]             launchShooter,
    output logic                      playerFireDenied,
    output logic                      cooldownBusy
`ifdef PROJ_ALLOC_STATS_EN
    ,
    output logic [7:0]                dropCount
`endif
);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        SERVE_PLAYER = 2'd1,
        SERVE_ENEMY  = 2'd2
    } state_t;

    state_t                    state;
    state_t                    state_next;

    logic                      pend_player;
    logic [ENEMY_SHOOTERS-1:0] pend_enemy;
    logic [SW-1:0]             rr_ptr;
    logic [7:0]                cooldown;

    logic [TOTAL-1:0]          player_pick;
    logic                      player_found;
    logic [TOTAL-1:0]          enemy_pick;
    logic                      enemy_found;
    logic [SW-1:0]             shooter_sel;
    logic                      shooter_found;
    logic [SW-1:0]             ptr_next;

    logic [TOTAL-1:0]          launch_mask;
    logic                      load_cool;
    logic                      clr_player;
    logic [ENEMY_SHOOTERS-1:0] clr_enemy;
    logic                      serve_deny;
    logic                      drop;
    logic                      enemy_launch;
    logic                      adv_ptr;

    // Lowest free slot in each pool, taken from registered occupancy so a
    // slot released this cycle only becomes eligible on the following one.
    always_comb begin
        player_pick  = '0;
        player_found = 1'b0;
        for (int i = ENEMY_PROJECTILES; i < TOTAL; i++) begin
            if (!player_found && !slotActive[i]) begin
                player_pick[i] = 1'b1;
                player_found   = 1'b1;
            end
        end
        enemy_pick  = '0;
        enemy_found = 1'b0;
        for (int i = 0; i < ENEMY_PROJECTILES; i++) begin
            if (!enemy_found && !slotActive[i]) begin
                enemy_pick[i] = 1'b1;
                enemy_found   = 1'b1;
            end
        end
    end

    // Round-robin: first pending shooter at or after the pointer, wrapping.
    always_comb begin
        shooter_sel   = rr_ptr;
        shooter_found = 1'b0;
        for (int k = 0; k < ENEMY_SHOOTERS; k++) begin
            if (!shooter_found && pend_enemy[(int'(rr_ptr) + k) % ENEMY_SHOOTERS]) begin
                shooter_sel   = SW'((int'(rr_ptr) + k) % ENEMY_SHOOTERS);
                shooter_found = 1'b1;
            end
        end
        ptr_next = (int'(shooter_sel) == ENEMY_SHOOTERS - 1) ? '0 : shooter_sel + SW'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        launch_mask  = '0;
        load_cool    = 1'b0;
        clr_player   = 1'b0;
        clr_enemy    = '0;
        serve_deny   = 1'b0;
        drop         = 1'b0;
        enemy_launch = 1'b0;
        adv_ptr      = 1'b0;
        case (state)
            IDLE: begin
                if (pend_player) begin
                    state_next = SERVE_PLAYER;
                end else if (|pend_enemy) begin
                    state_next = SERVE_ENEMY;
                end
            end
            SERVE_PLAYER: begin
                clr_player = 1'b1;
                state_next = IDLE;
                if (player_found) begin
                    launch_mask = player_pick;
                    load_cool   = 1'b1;
                end else begin
                    serve_deny = 1'b1;
                    drop       = 1'b1;
                end
            end
            SERVE_ENEMY: begin
                // The served request is consumed whether or not it launches.
                clr_enemy  = ENEMY_SHOOTERS'(1) << shooter_sel;
                adv_ptr    = 1'b1;
                state_next = IDLE;
                if (enemy_found) begin
                    launch_mask  = enemy_pick;
                    enemy_launch = 1'b1;
                end else begin
                    drop = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slotActive       <= '0;
            slotLaunch       <= '0;
            launchShooter    <= '0;
            playerFireDenied <= 1'b0;
            pend_player      <= 1'b0;
            pend_enemy       <= '0;
            rr_ptr           <= '0;
            cooldown         <= '0;
        end else begin
            slotActive       <= (slotActive & ~slotRelease) | launch_mask;
            slotLaunch       <= launch_mask;
            launchShooter    <= enemy_launch ? shooter_sel : '0;
            playerFireDenied <= serve_deny | (playerFireReq & cooldownBusy);
            // A new request arriving on the clearing edge stays pending.
            pend_player      <= (pend_player & ~clr_player) | (playerFireReq & ~cooldownBusy);
            pend_enemy       <= (pend_enemy & ~clr_enemy) | enemyFireReq;
            if (adv_ptr) begin
                rr_ptr <= ptr_next;
            end
            if (load_cool) begin
                cooldown <= 8'(COOLDOWN_FRAMES);
            end else if (startOfFrame && cooldown != 8'd0) begin
                cooldown <= cooldown - 8'd1;
            end
        end
    end

    assign cooldownBusy = (cooldown != 8'd0);

`ifdef PROJ_ALLOC_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dropCount <= 8'd0;
        end else if (drop && dropCount != 8'hFF) begin
            dropCount <= dropCount + 8'd1;
        end
    end
`else
    logic unused_drop;
    assign unused_drop = drop;
`endif

endmodule

// File: tb/tb_projectile_slot_allocator.sv
// tb/tb_projectile_slot_allocator.sv - self-checking bench for projectile_slot_allocator

module tb_projectile_slot_allocator;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        startOfFrame = 1'b0;
    logic        playerFireReq = 1'b0;
    logic [3:0]  enemyFireReq = '0;
    logic [11:0] slotRelease = '0;
    logic [11:0] slotActive;
    logic [11:0] slotLaunch;
    logic [1:0]  launchShooter;
    logic        playerFireDenied;
    logic        cooldownBusy;
`ifdef PROJ_ALLOC_STATS_EN
    logic [7:0]  dropCount;
`endif

    projectile_slot_allocator #(
        .ENEMY_PROJECTILES (8),
        .PLAYER_PROJECTILES(4),
        .ENEMY_SHOOTERS    (4),
        .COOLDOWN_FRAMES   (6)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .startOfFrame    (startOfFrame),
        .playerFireReq   (playerFireReq),
        .enemyFireReq    (enemyFireReq),
        .slotRelease     (slotRelease),
        .slotActive      (slotActive),
        .slotLaunch      (slotLaunch),
        .launchShooter   (launchShooter),
        .playerFireDenied(playerFireDenied),
        .cooldownBusy    (cooldownBusy)
`ifdef PROJ_ALLOC_STATS_EN
        ,
        .dropCount       (dropCount)
`endif
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: who gets served next, which pool slot is free,
    // how many frames the player still has to wait.
    logic [11:0] m_active;
    logic [11:0] m_launch;
    int          m_shooter;
    bit          m_denied;
    int          m_cool;
    int          m_drop;
    bit          m_player_pending;
    bit          m_enemy_pending[4];
    int          m_ptr;
    int          m_turn;      // 0 nobody, 1 player served next edge, 2 enemy served next edge
    int          t_next_turn;
    int          t_slot;
    int          t_j;
    bit          t_load;
    bit          t_any;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_active = '0; m_launch = '0; m_shooter = 0; m_denied = 0;
            m_cool = 0; m_drop = 0; m_player_pending = 0; m_ptr = 0; m_turn = 0;
            for (int i = 0; i < 4; i++) m_enemy_pending[i] = 0;
        end else begin
            t_any = 0;
            for (int i = 0; i < 4; i++) if (m_enemy_pending[i]) t_any = 1;
            t_next_turn = 0;
            if (m_turn == 0) t_next_turn = m_player_pending ? 1 : (t_any ? 2 : 0);
            m_launch = '0; m_shooter = 0; m_denied = 0; t_load = 0;
            t_slot = -1;
            if (m_turn == 1) begin
                for (int s = 11; s >= 8; s--) if (!m_active[s]) t_slot = s;
                m_player_pending = 0;
                if (t_slot >= 0) begin
                    m_launch[t_slot] = 1'b1;
                    t_load = 1;
                end else begin
                    m_denied = 1;
                    if (m_drop < 255) m_drop++;
                end
            end else if (m_turn == 2) begin
                t_j = -1;
                for (int k = 3; k >= 0; k--) if (m_enemy_pending[(m_ptr + k) % 4]) t_j = (m_ptr + k) % 4;
                for (int s = 7; s >= 0; s--) if (!m_active[s]) t_slot = s;
                m_enemy_pending[t_j] = 0;
                m_ptr = (t_j + 1) % 4;
                if (t_slot >= 0) begin
                    m_launch[t_slot] = 1'b1;
                    m_shooter = t_j;
                end else begin
                    if (m_drop < 255) m_drop++;
                end
            end
            if (playerFireReq) begin
                if (m_cool != 0) m_denied = 1;
                else m_player_pending = 1;
            end
            for (int i = 0; i < 4; i++) if (enemyFireReq[i]) m_enemy_pending[i] = 1;
            m_active = (m_active & ~slotRelease) | m_launch;
            if (t_load) m_cool = 6;
            else if (startOfFrame && m_cool > 0) m_cool--;
            m_turn = t_next_turn;
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            check("slotActive", 32'(slotActive), 32'(m_active));
            check("slotLaunch", 32'(slotLaunch), 32'(m_launch));
            check("launchShooter", 32'(launchShooter), 32'(m_shooter));
            check("playerFireDenied", 32'(playerFireDenied), 32'(m_denied));
            check("cooldownBusy", 32'(cooldownBusy), 32'(m_cool != 0));
`ifdef PROJ_ALLOC_STATS_EN
            check("dropCount", 32'(dropCount), 32'(m_drop));
`endif
        end
    end

    task automatic cyc(input bit pf, input logic [3:0] ef, input logic [11:0] rel, input bit sof);
        playerFireReq = pf;
        enemyFireReq  = ef;
        slotRelease   = rel;
        startOfFrame  = sof;
        @(negedge clk);
        #1;
        playerFireReq = 1'b0;
        enemyFireReq  = '0;
        slotRelease   = '0;
        startOfFrame  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 4'h0, 12'h000, 1'b0);
    endtask

    task automatic frames(input int n);
        repeat (n) cyc(1'b0, 4'h0, 12'h000, 1'b1);
    endtask

    task automatic check_drop(input string name, input int exp);
`ifdef PROJ_ALLOC_STATS_EN
        check(name, 32'(dropCount), 32'(exp));
`endif
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #1;
        check("reset slotActive", 32'(slotActive), 32'h0);
        check("reset slotLaunch", 32'(slotLaunch), 32'h0);
        check("reset cooldownBusy", 32'(cooldownBusy), 32'h0);
        reset = 1'b0;

        // 1: first player launch into slot 8
        cyc(1'b1, 4'h0, 12'h000, 1'b0);
        idle(1);
        check("t1 no early launch", 32'(slotLaunch), 32'h0);
        idle(1);
        check("t1 slotLaunch", 32'(slotLaunch), 32'h100);
        check("t1 slotActive", 32'(slotActive), 32'h100);
        check("t1 cooldownBusy", 32'(cooldownBusy), 32'h1);
        idle(1);
        check("t1 launch one cycle", 32'(slotLaunch), 32'h0);

        // 2: cooldown denial, then launch into slot 9 after six frames
        cyc(1'b1, 4'h0, 12'h000, 1'b0);
        check("t2 denied pulse", 32'(playerFireDenied), 32'h1);
        idle(1);
        check("t2 denied one cycle", 32'(playerFireDenied), 32'h0);
        idle(1);
        check("t2 no launch", 32'(slotActive), 32'h100);
        frames(5);
        check("t2 busy after 5", 32'(cooldownBusy), 32'h1);
        frames(1);
        check("t2 idle after 6", 32'(cooldownBusy), 32'h0);
        cyc(1'b1, 4'h0, 12'h000, 1'b0);
        idle(2);
        check("t2 slotLaunch", 32'(slotLaunch), 32'h200);
        check("t2 slotActive", 32'(slotActive), 32'h300);
        frames(6);

        // 3: player first, then enemies 0..3 round-robin
        cyc(1'b1, 4'hF, 12'h000, 1'b0);
        idle(2);
        check("t3 player first", 32'(slotLaunch), 32'h400);
        for (int i = 0; i < 4; i++) begin
            idle(2);
            check("t3 enemy slot", 32'(slotLaunch), 32'(1 << i));
            check("t3 enemy shooter", 32'(launchShooter), 32'(i));
        end
        check("t3 slotActive", 32'(slotActive), 32'h70F);

        // 4: fill enemy pool, then a drop advances the pointer to 3
        cyc(1'b0, 4'hF, 12'h000, 1'b0);
        idle(8);
        check("t4 pool full", 32'(slotActive), 32'h7FF);
        cyc(1'b0, 4'b0100, 12'h000, 1'b0);
        idle(3);
        check("t4 no launch", 32'(slotActive), 32'h7FF);
        check_drop("t4 dropCount", 1);
        cyc(1'b0, 4'h0, 12'h003, 1'b0);
        cyc(1'b0, 4'b1001, 12'h000, 1'b0);
        idle(2);
        check("t4 ptr slot", 32'(slotLaunch), 32'h001);
        check("t4 ptr shooter3", 32'(launchShooter), 32'h3);
        idle(2);
        check("t4 wrap slot", 32'(slotLaunch), 32'h002);
        check("t4 wrap shooter0", 32'(launchShooter), 32'h0);

        // 5: release on the serve edge is too late; repeat request reuses slot 3
        cyc(1'b0, 4'b0001, 12'h000, 1'b0);
        idle(1);
        cyc(1'b0, 4'h0, 12'h008, 1'b0);
        check("t5 dropped", 32'(slotLaunch), 32'h0);
        check("t5 released", 32'(slotActive), 32'h7F7);
        check_drop("t5 dropCount", 2);
        cyc(1'b0, 4'b0001, 12'h000, 1'b0);
        idle(2);
        check("t5 reuse slot3", 32'(slotLaunch), 32'h008);
        check("t5 reuse shooter", 32'(launchShooter), 32'h0);

        // 7: player pool boundary: slot 11 last, then pool-full denial
        frames(6);
        cyc(1'b1, 4'h0, 12'h000, 1'b0);
        idle(2);
        check("t7 slot11", 32'(slotLaunch), 32'h800);
        check("t7 all active", 32'(slotActive), 32'hFFF);
        frames(6);
        cyc(1'b1, 4'h0, 12'h000, 1'b0);
        idle(2);
        check("t7 full denied", 32'(playerFireDenied), 32'h1);
        check("t7 full no launch", 32'(slotLaunch), 32'h0);
        check_drop("t7 dropCount", 3);

        // 6: reset while serving an enemy
        cyc(1'b0, 4'h0, 12'h001, 1'b0);
        cyc(1'b0, 4'b0010, 12'h000, 1'b0);
        idle(1);
        reset = 1'b1;
        #1;
        check("t6 async slotActive", 32'(slotActive), 32'h0);
        check("t6 async slotLaunch", 32'(slotLaunch), 32'h0);
        check("t6 async shooter", 32'(launchShooter), 32'h0);
        check("t6 async busy", 32'(cooldownBusy), 32'h0);
        check_drop("t6 async dropCount", 0);
        @(negedge clk);
        #1;
        reset = 1'b0;
        idle(3);
        check("t6 no launch after", 32'(slotLaunch), 32'h0);
        check("t6 pending cleared", 32'(slotActive), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
